lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store controller for the CPU's data-memory port. Accepts one byte, halfword or word load/store request from the datapath and sequences the word-wide data memory (write enable, word address, write data, combinational read data). Sub-word stores are performed as read-modify-write. Sits between the EX/MEM stage and the data memory and acts as the initiator of the memory protocol.

## Interface
- ADDR_W, 32, byte-address width; data width is fixed at 32.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  request strobe; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  access size: 00 byte, 01 half, 10 word; 11 treated as word.
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rdata  out  32  load result, extended; held until the next load completes.
- done  out  1  one-cycle completion pulse.
- err  out  1  misaligned-access pulse, coincident with done.
- busy  out  1  high whenever state is not IDLE.
- dm_we  out  1  data-memory write enable.
- dm_addr  out  ADDR_W  word-aligned address: {addr[ADDR_W-1:2], 2'b00}.
- dm_wdata  out  32  full word to write.
- dm_rdata  in  32  data-memory read data, combinational on dm_addr.

## Operation
- Lanes are little-endian: byte offset o = addr[1:0] selects bits [8o+7:8o]; a halfword at offset o occupies bytes o and o+1.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - on req, latch addr, we, size, sign_ext and wdata.
  - Misaligned access (see Configuration) goes to DONE with err set and no memory access.
  - Word store goes to WR.
  - All other accesses go to RD.
- RD:
  - dm_addr driven; dm_rdata captured at the clock edge.
  - Load: extract the lane, extend it, register it into rdata, then go to DONE.
  - Sub-word store: merge the new lanes into the captured word, then go to WR.
- WR: dm_we=1 for exactly one cycle with the merged word (or wdata for a word store); the memory writes at the edge ending WR; then DONE.
- DONE: done=1 (err=1 if misaligned) for one cycle; then IDLE. req is ignored outside IDLE.
- Stores never modify rdata. A misaligned load leaves rdata unchanged.
- Reset values: state IDLE; rdata, done, err, busy, dm_we, dm_addr and dm_wdata all 0. dm_wdata is 0 outside WR.
- Reset asserted mid-operation aborts immediately and asynchronously: dm_we drops at once, so a partially sequenced RMW writes nothing. There is no done pulse for the aborted request.

## Timing
- All outputs are registered or decoded from registered state only; nothing combinational from req to dm_*.
- Sequences, with edge E0 = the edge that samples req:
  - Load: RD after E0; done high in the cycle after E1 (latency 2 edges, 3 cycles req-to-req).
  - Word store: WR after E0; write at E1; done after E1.
  - Sub-word store: RD, then WR; write at E2; done after E2.
  - Misaligned access: done and err high in the cycle after E0.
- Next request is sampled no earlier than the edge ending DONE, i.e. in the first IDLE cycle.
- dm_addr is stable for the whole RD/WR span of one request.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - half with addr[0]=1, or word with addr[1:0]≠0, is rejected: err and done pulse, dm_we never asserted, rdata unchanged.
- Not defined:
  - err is tied 0.
  - Offending low address bits are cleared (half uses offset addr[1]*2; word uses offset 0) and the access proceeds normally.

## Structure
- Package lsu_pkg:
  - size encodings SZ_B, SZ_H, SZ_W.
  - state enum.
  - constant DATA_W = 32.
- Sub-module lsu_lane_merge, purely combinational:
  - extract(word, offset, size, sign_ext) → extended load value.
  - merge(old_word, wdata, offset, size) → store word.
  - Instantiated once.

## Test plan
- Word store then load:
  - Store addr 0x10, wdata 0x0000_1111: dm_we high exactly one cycle with dm_addr=0x10, dm_wdata=0x0000_1111.
  - Then load word 0x10: rdata=0x0000_1111, done 2 edges after req.
- Byte RMW:
  - Memory word 0x10 = 0xAABBCCDD; store byte 0x11 with wdata 0x55: read cycle then write of 0xAABB55DD.
  - Load byte 0x11 sign_ext=1: rdata=0x0000_0055.
- Sign extension:
  - Memory 0x20 = 0x8000_F0FF.
  - Load half 0x22, sign_ext=1: rdata=0xFFFF_8000.
  - Load byte 0x20, sign_ext=0: rdata=0x0000_00FF.
- Misaligned access:
  - Trap build: load word 0x13 gives err=done=1 one cycle after req, rdata unchanged, no dm_we.
  - Trap build: store half 0x15 gives the same, with dm_we never asserted.
  - Non-trap build: load word 0x13 reads word 0x10.
- Reset mid-RMW:
  - Store byte 0x12, then assert reset during RD: no dm_we ever asserted, all outputs 0, busy=0, memory word unchanged.
- Busy handling:
  - Pulse req again during RD: ignored, exactly one done observed.
  - req held high through DONE: second request starts in the following IDLE cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store controller.
package lsu_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_DONE
  } state_e;

  // Encoding 2'b11 behaves as a word access.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// Combinational lane logic: extracts/extends a load lane and merges store lanes into a word.
module lsu_lane_merge
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] word_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [1:0]        offset_i,
  input  logic [1:0]        size_i,
  input  logic              sign_ext_i,
  output logic [DATA_W-1:0] load_o,
  output logic [DATA_W-1:0] store_o
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] lanes;

  always_comb begin
    shifted = word_i >> {offset_i, 3'b000};
    load_o  = shifted;
    mask    = '1;
    lanes   = wdata_i;
    if (size_i == SZ_B) begin
      load_o = {{24{sign_ext_i & shifted[7]}}, shifted[7:0]};
      mask   = 32'h0000_00FF << {offset_i, 3'b000};
      lanes  = wdata_i << {offset_i, 3'b000};
    end else if (size_i == SZ_H) begin
      load_o = {{16{sign_ext_i & shifted[15]}}, shifted[15:0]};
      mask   = 32'h0000_FFFF << {offset_i, 3'b000};
      lanes  = wdata_i << {offset_i, 3'b000};
    end
    store_o = (word_i & ~mask) | (lanes & mask);
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer for a word-wide data memory; sub-word stores are read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses with err instead of aligning them down.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              err,
  output logic              busy,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              mis_q, mis_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [1:0]        off_in;
  logic              mis_in;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] store_val;

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis_in = ((size == SZ_H) && addr[0]) || (is_word(size) && (addr[1:0] != 2'b00));
  assign off_in = addr[1:0];
`else
  assign mis_in = 1'b0;
  // Misaligned accesses are aligned down to the natural boundary of their size.
  assign off_in = is_word(size)  ? 2'b00 :
                  (size == SZ_H) ? {addr[1], 1'b0} : addr[1:0];
`endif

  lsu_lane_merge u_lane_merge (
    .word_i     (dm_rdata),
    .wdata_i    (word_q),
    .offset_i   (addr_q[1:0]),
    .size_i     (size_q),
    .sign_ext_i (sext_q),
    .load_o     (load_val),
    .store_o    (store_val)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    word_d  = word_q;
    mis_d   = mis_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d  = {addr[ADDR_W-1:2], off_in};
          we_d    = we;
          size_d  = size;
          sext_d  = sign_ext;
          word_d  = wdata;
          mis_d   = mis_in;
          if (mis_in)                  state_d = ST_DONE;
          else if (we && is_word(size)) state_d = ST_WR;
          else                          state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (we_q) begin
          word_d  = store_val;
          state_d = ST_WR;
        end else begin
          rdata_d = load_val;
          state_d = ST_DONE;
        end
      end
      ST_WR:   state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      sext_q  <= 1'b0;
      word_q  <= '0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      word_q  <= word_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
    end
  end

  // Everything below decodes registered state, so reset drops dm_we immediately.
  assign dm_we    = (state_q == ST_WR);
  assign dm_wdata = dm_we ? word_q : '0;
  assign dm_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign done     = (state_q == ST_DONE);
  assign err      = done & mis_q;
  assign busy     = (state_q != ST_IDLE);
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: vector table plus hand-written reset and busy sequences.
module tb_lsu_ctrl;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic        exp_wr;
    logic [31:0] exp_waddr;
    logic [31:0] exp_wdat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        done, err, busy, dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;

  logic [31:0] mem [0:63];
  int          checks = 0;
  int          errors = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] wr_addr, wr_dat;
  logic        prev_busy = 1'b0;
  logic [31:0] prev_addr = '0;
  exp_t        sbq[$];
  vec_t        vecs[18];

  always #5 clk = ~clk;

  lsu_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err), .busy(busy),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata)
  );

  assign dm_rdata = mem[dm_addr[7:2]];
  always @(posedge clk) if (dm_we) mem[dm_addr[7:2]] <= dm_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard pop on done, plus memory-port protocol checks every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (dm_we) begin
      wr_cnt++;
      wr_addr = dm_addr;
      wr_dat  = dm_wdata;
    end else begin
      chk("dm_wdata_idle_zero", dm_wdata, 32'h0);
    end
    if (err && !done) chk("err_without_done", {31'b0, err}, 32'h0);
    if (busy && prev_busy) chk("dm_addr_stable", dm_addr, prev_addr);
    prev_busy = busy;
    prev_addr = dm_addr;
    if (done) begin
      done_cnt++;
      if (sbq.size() == 0) begin
        chk("unexpected_done", {31'b0, done}, 32'h0);
      end else begin
        e = sbq.pop_front();
        chk("sb_rdata", rdata, e.rdata);
        chk("sb_err", {31'b0, err}, {31'b0, e.err});
      end
    end
  end

  function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic sx,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] er, input logic ee, input int lat,
                              input logic ew, input logic [31:0] wa, input logic [31:0] wdt);
    vec_t v;
    v.we = w; v.size = sz; v.sext = sx; v.addr = a; v.wdata = wd;
    v.exp_rdata = er; v.exp_err = ee; v.exp_lat = lat;
    v.exp_wr = ew; v.exp_waddr = wa; v.exp_wdat = wdt;
    return v;
  endfunction

  task automatic drive(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd);
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
  endtask

  // Waits up to 20 cycles for done; returns the number of falling edges seen.
  task automatic wait_done(output int n, input bit drop_req);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (drop_req && n == 1) req = 1'b0;
    end while (!done && n < 20);
    if (!done) chk("done_timeout", 32'h0, 32'h1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n, w0;
    @(negedge clk);
    sbq.push_back('{v.exp_rdata, v.exp_err});
    w0 = wr_cnt;
    drive(v.we, v.size, v.sext, v.addr, v.wdata);
    wait_done(n, 1'b1);
    chk($sformatf("v%0d_latency", idx), n, v.exp_lat);
    chk($sformatf("v%0d_wr_count", idx), wr_cnt - w0, {31'b0, v.exp_wr});
    if (v.exp_wr) begin
      chk($sformatf("v%0d_wr_addr", idx), wr_addr, v.exp_waddr);
      chk($sformatf("v%0d_wr_data", idx), wr_dat, v.exp_wdat);
    end
  endtask

  initial begin
    int n, w0, d0;
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, w0, d0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;

    vecs[0]  = mk(1, 2'b10, 0, 32'h10, 32'h0000_1111, 32'h0,         0, 2, 1, 32'h10, 32'h0000_1111);
    vecs[1]  = mk(0, 2'b10, 0, 32'h10, 32'h0,         32'h0000_1111, 0, 2, 0, 32'h0,  32'h0);
    vecs[2]  = mk(1, 2'b10, 0, 32'h10, 32'hAABB_CCDD, 32'h0000_1111, 0, 2, 1, 32'h10, 32'hAABB_CCDD);
    vecs[3]  = mk(1, 2'b00, 0, 32'h11, 32'hFFFF_FF55, 32'h0000_1111, 0, 3, 1, 32'h10, 32'hAABB_55DD);
    vecs[4]  = mk(0, 2'b00, 1, 32'h11, 32'h0,         32'h0000_0055, 0, 2, 0, 32'h0,  32'h0);
    vecs[5]  = mk(1, 2'b10, 0, 32'h20, 32'h8000_F0FF, 32'h0000_0055, 0, 2, 1, 32'h20, 32'h8000_F0FF);
    vecs[6]  = mk(0, 2'b01, 1, 32'h22, 32'h0,         32'hFFFF_8000, 0, 2, 0, 32'h0,  32'h0);
    vecs[7]  = mk(0, 2'b00, 0, 32'h20, 32'h0,         32'h0000_00FF, 0, 2, 0, 32'h0,  32'h0);
    vecs[8]  = mk(0, 2'b01, 0, 32'h22, 32'h0,         32'h0000_8000, 0, 2, 0, 32'h0,  32'h0);
    vecs[9]  = mk(0, 2'b00, 1, 32'h21, 32'h0,         32'hFFFF_FFF0, 0, 2, 0, 32'h0,  32'h0);
    vecs[10] = mk(1, 2'b01, 0, 32'h22, 32'hABCD_1234, 32'hFFFF_FFF0, 0, 3, 1, 32'h20, 32'h1234_F0FF);
    vecs[11] = mk(0, 2'b10, 0, 32'h20, 32'h0,         32'h1234_F0FF, 0, 2, 0, 32'h0,  32'h0);
    vecs[12] = mk(1, 2'b11, 0, 32'h24, 32'hDEAD_BEEF, 32'h1234_F0FF, 0, 2, 1, 32'h24, 32'hDEAD_BEEF);
    vecs[13] = mk(0, 2'b11, 0, 32'h24, 32'h0,         32'hDEAD_BEEF, 0, 2, 0, 32'h0,  32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[14] = mk(0, 2'b10, 0, 32'h13, 32'h0,         32'hDEAD_BEEF, 1, 1, 0, 32'h0,  32'h0);
    vecs[15] = mk(1, 2'b01, 0, 32'h15, 32'h1234_7777, 32'hDEAD_BEEF, 1, 1, 0, 32'h0,  32'h0);
    vecs[16] = mk(0, 2'b01, 0, 32'h15, 32'h0,         32'hDEAD_BEEF, 1, 1, 0, 32'h0,  32'h0);
`else
    vecs[14] = mk(0, 2'b10, 0, 32'h13, 32'h0,         32'hAABB_55DD, 0, 2, 0, 32'h0,  32'h0);
    vecs[15] = mk(1, 2'b01, 0, 32'h15, 32'h1234_7777, 32'hAABB_55DD, 0, 3, 1, 32'h14, 32'h0000_7777);
    vecs[16] = mk(0, 2'b01, 0, 32'h15, 32'h0,         32'h0000_7777, 0, 2, 0, 32'h0,  32'h0);
`endif
    vecs[17] = mk(0, 2'b00, 1, 32'h13, 32'h0,         32'hFFFF_FFAA, 0, 2, 0, 32'h0,  32'h0);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_dm_we", {31'b0, dm_we}, 32'h0);
    chk("rst_dm_addr", dm_addr, 32'h0);
    chk("rst_dm_wdata", dm_wdata, 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 18; i++) run_vec(i, vecs[i]);

    // Reset asserted during the read phase of a byte RMW
    @(negedge clk);
    w0 = wr_cnt;
    drive(1'b1, 2'b00, 1'b0, 32'h12, 32'h0000_0099);
    @(negedge clk);
    req = 1'b0;
    chk("rmw_busy_in_rd", {31'b0, busy}, 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("abort_rdata", rdata, 32'h0);
    chk("abort_done", {31'b0, done}, 32'h0);
    chk("abort_err", {31'b0, err}, 32'h0);
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_dm_we", {31'b0, dm_we}, 32'h0);
    chk("abort_dm_addr", dm_addr, 32'h0);
    chk("abort_dm_wdata", dm_wdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_write", wr_cnt - w0, 32'h0);
    chk("abort_mem_intact", mem[4], 32'hAABB_55DD);

    // Extra req pulse while busy is ignored
    @(negedge clk);
    d0 = done_cnt;
    sbq.push_back('{32'hAABB_55DD, 1'b0});
    drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    chk("pulse_busy_in_rd", {31'b0, busy}, 32'h1);
    addr = 32'h20;
    @(negedge clk);
    req = 1'b0;
    repeat (8) @(negedge clk);
    chk("pulse_single_done", done_cnt - d0, 32'h1);

    // req held through DONE: the next request starts in the first IDLE cycle
    @(negedge clk);
    d0 = done_cnt;
    sbq.push_back('{32'hAABB_55DD, 1'b0});
    sbq.push_back('{32'h1234_F0FF, 1'b0});
    drive(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    wait_done(n, 1'b0);
    chk("held_first_latency", n, 32'd2);
    addr = 32'h20;
    wait_done(n, 1'b0);
    chk("held_second_spacing", n, 32'd3);
    req = 1'b0;
    repeat (6) @(negedge clk);
    chk("held_done_count", done_cnt - d0, 32'h2);
    chk("sb_drained", sbq.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
